// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types: access direction and 2-bit access status.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'd0,
    RGGEN_EXOKAY       = 2'd1,
    RGGEN_SLAVE_ERROR  = 2'd2,
    RGGEN_DECODE_ERROR = 2'd3
  } rggen_status;

endpackage

// File: rtl/rggen_host_adapter_axi4lite_if.sv
// AXI4-Lite host side plus register-bus side of the host adapter.
// slave modport: the adapter; master modport: host and register fabric.
interface rggen_host_adapter_axi4lite_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                      i_awvalid;
  logic                      o_awready;
  logic [ADDRESS_WIDTH-1:0]  i_awaddr;
  logic                      i_wvalid;
  logic                      o_wready;
  logic [DATA_WIDTH-1:0]     i_wdata;
  logic [DATA_WIDTH/8-1:0]   i_wstrb;
  logic                      o_bvalid;
  logic                      i_bready;
  logic [1:0]                o_bresp;
  logic                      i_arvalid;
  logic                      o_arready;
  logic [ADDRESS_WIDTH-1:0]  i_araddr;
  logic                      o_rvalid;
  logic                      i_rready;
  logic [DATA_WIDTH-1:0]     o_rdata;
  logic [1:0]                o_rresp;
  logic                      o_request;
  logic                      o_direction;
  logic [ADDRESS_WIDTH-1:0]  o_address;
  logic [DATA_WIDTH-1:0]     o_write_data;
  logic [DATA_WIDTH-1:0]     o_write_mask;
  logic                      i_ready;
  logic [DATA_WIDTH-1:0]     i_read_data;
  logic [1:0]                i_status;

  modport slave (
    input  i_awvalid, i_awaddr, i_wvalid, i_wdata, i_wstrb, i_bready,
           i_arvalid, i_araddr, i_rready, i_ready, i_read_data, i_status,
    output o_awready, o_wready, o_bvalid, o_bresp, o_arready, o_rvalid,
           o_rdata, o_rresp, o_request, o_direction, o_address,
           o_write_data, o_write_mask
  );

  modport master (
    output i_awvalid, i_awaddr, i_wvalid, i_wdata, i_wstrb, i_bready,
           i_arvalid, i_araddr, i_rready, i_ready, i_read_data, i_status,
    input  o_awready, o_wready, o_bvalid, o_bresp, o_arready, o_rvalid,
           o_rdata, o_rresp, o_request, o_direction, o_address,
           o_write_data, o_write_mask
  );
endinterface

// File: rtl/rggen_host_adapter_axi4lite_timer.sv
// Access timer: counts ACCESS cycles without i_ready and flags the last
// allowed cycle. Only instantiated when RGGEN_HOST_ACCESS_TIMEOUT_EN is set.
module rggen_host_access_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Clear on grant, count waiting cycles, saturate at the expiry value.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_count && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign o_expired = (count_q == LAST);
endmodule

// File: rtl/rggen_host_adapter_axi4lite.sv
// AXI4-Lite to register-bus host adapter: one outstanding access,
// round-robin read/write arbitration. Optional access timeout enabled by
// defining RGGEN_HOST_ACCESS_TIMEOUT_EN.
module rggen_host_adapter_axi4lite
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                           clk,
  input logic                           rst,
  rggen_host_adapter_axi4lite_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESPONSE
  } state_e;

  if (!((DATA_WIDTH == 32) || (DATA_WIDTH == 64)) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
    $error("rggen_host_adapter_axi4lite: DATA_WIDTH must be 32/64 and TIMEOUT_CYCLES >= 2");
  end

  state_e                    state_q, state_d;
  rggen_direction            last_grant_q, last_grant_d;
  rggen_direction            direction_q, direction_d;
  logic [ADDRESS_WIDTH-1:0]  address_q, address_d;
  logic [DATA_WIDTH-1:0]     write_data_q, write_data_d;
  logic [DATA_WIDTH-1:0]     write_mask_q, write_mask_d;
  logic [DATA_WIDTH-1:0]     read_data_q, read_data_d;
  logic [1:0]                status_q, status_d;
  logic [DATA_WIDTH-1:0]     strb_mask;
  logic                      write_pending, read_pending;
  logic                      grant_write, grant_read;
  logic                      bvalid, rvalid;

  assign write_pending = bus.i_awvalid && bus.i_wvalid;
  assign read_pending  = bus.i_arvalid;

`ifdef RGGEN_HOST_ACCESS_TIMEOUT_EN
  logic timeout_expired;

  rggen_host_access_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (grant_write || grant_read),
    .i_count   ((state_q == ST_ACCESS) && !bus.i_ready),
    .o_expired (timeout_expired)
  );
`endif

  // Expand byte strobes to a bit mask.
  always_comb begin
    strb_mask = '0;
    for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
      strb_mask[8*i +: 8] = {8{bus.i_wstrb[i]}};
    end
  end

  // Next-state, arbitration and capture logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    direction_d  = direction_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    write_mask_d = write_mask_q;
    read_data_d  = read_data_q;
    status_d     = status_q;
    grant_write  = 1'b0;
    grant_read   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        grant_write = write_pending && (!read_pending || (last_grant_q == RGGEN_READ));
        grant_read  = read_pending && !grant_write;
        if (grant_write) begin
          direction_d  = RGGEN_WRITE;
          address_d    = bus.i_awaddr;
          write_data_d = bus.i_wdata;
          write_mask_d = strb_mask;
          last_grant_d = RGGEN_WRITE;
          state_d      = ST_ACCESS;
        end else if (grant_read) begin
          direction_d  = RGGEN_READ;
          address_d    = bus.i_araddr;
          write_data_d = '0;
          write_mask_d = '0;
          last_grant_d = RGGEN_READ;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (bus.i_ready) begin
          read_data_d = (direction_q == RGGEN_READ) ? bus.i_read_data : '0;
          status_d    = bus.i_status;
          state_d     = ST_RESPONSE;
        end
`ifdef RGGEN_HOST_ACCESS_TIMEOUT_EN
        else if (timeout_expired) begin
          read_data_d = '0;
          status_d    = RGGEN_SLAVE_ERROR;
          state_d     = ST_RESPONSE;
        end
`endif
      end
      ST_RESPONSE: begin
        if ((direction_q == RGGEN_WRITE) ? bus.i_bready : bus.i_rready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-transaction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= RGGEN_READ;
      direction_q  <= RGGEN_READ;
      address_q    <= '0;
      write_data_q <= '0;
      write_mask_q <= '0;
      read_data_q  <= '0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      direction_q  <= direction_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      write_mask_q <= write_mask_d;
      read_data_q  <= read_data_d;
      status_q     <= status_d;
    end
  end

  assign bvalid = (state_q == ST_RESPONSE) && (direction_q == RGGEN_WRITE);
  assign rvalid = (state_q == ST_RESPONSE) && (direction_q == RGGEN_READ);

  assign bus.o_awready    = grant_write;
  assign bus.o_wready     = grant_write;
  assign bus.o_arready    = grant_read;
  assign bus.o_bvalid     = bvalid;
  assign bus.o_bresp      = bvalid ? status_q : 2'b00;
  assign bus.o_rvalid     = rvalid;
  assign bus.o_rresp      = rvalid ? status_q : 2'b00;
  assign bus.o_rdata      = rvalid ? read_data_q : '0;
  assign bus.o_request    = (state_q == ST_ACCESS);
  assign bus.o_direction  = direction_q;
  assign bus.o_address    = address_q;
  assign bus.o_write_data = write_data_q;
  assign bus.o_write_mask = write_mask_q;
endmodule

// File: tb/tb_rggen_host_adapter_axi4lite.sv
// Self-checking bench for rggen_host_adapter_axi4lite. Expected accesses are
// queued when stimulus is driven and popped when responses appear.
module tb_rggen_host_adapter_axi4lite;
  import rggen_rtl_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;

  typedef struct {
    logic          dir;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mask;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rggen_host_adapter_axi4lite_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rggen_host_adapter_axi4lite #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic test_reset();
    rst = 1'b1;
    bus.i_awvalid = 1'b0; bus.i_awaddr = '0; bus.i_wvalid = 1'b0;
    bus.i_wdata = '0; bus.i_wstrb = '0; bus.i_bready = 1'b0;
    bus.i_arvalid = 1'b0; bus.i_araddr = '0; bus.i_rready = 1'b0;
    bus.i_ready = 1'b0; bus.i_read_data = '0; bus.i_status = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.o_request, bus.o_awready, bus.o_wready, bus.o_arready, bus.o_bvalid, bus.o_rvalid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.o_request, bus.o_awready, bus.o_wready, bus.o_arready, bus.o_bvalid, bus.o_rvalid});
    end
    checks++;
    if ({bus.o_direction, bus.o_address, bus.o_write_data, bus.o_write_mask, bus.o_rdata, bus.o_bresp, bus.o_rresp} !== '0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h wd=%h wm=%h rd=%h expected all 0",
               bus.o_address, bus.o_write_data, bus.o_write_mask, bus.o_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete access: optional AW-only lead, grant, register-bus phase,
  // response with optional backpressure hold, handshake.
  task automatic single_access(input string name, input logic is_write, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW/8-1:0] strb,
                               input logic [DW-1:0] mask, input logic [DW-1:0] rd,
                               input logic [1:0] st, input int unsigned aw_lead, input int unsigned hold);
    exp_t e, got;
    logic [37:0] resp_exp;
    e.dir = is_write; e.addr = addr;
    e.wdata = is_write ? wdata : '0;
    e.mask  = is_write ? mask : '0;
    e.rdata = is_write ? '0 : rd;
    e.resp  = st;
    exp_q.push_back(e);
    @(negedge clk);
    if (is_write) begin
      bus.i_awvalid = 1'b1; bus.i_awaddr = addr; bus.i_wdata = wdata; bus.i_wstrb = strb;
      for (int unsigned c = 0; c < aw_lead; c++) begin
        #1;
        checks++;
        if ({bus.o_awready, bus.o_wready, bus.o_request} !== 3'b000) begin
          failures++;
          $display("FAIL %s aw_only cycle %0d: got awready/wready/request=%b expected 000",
                   name, c, {bus.o_awready, bus.o_wready, bus.o_request});
        end
        @(negedge clk);
      end
      bus.i_wvalid = 1'b1;
    end else begin
      bus.i_arvalid = 1'b1; bus.i_araddr = addr;
    end
    #1;
    checks++;
    if ({bus.o_awready, bus.o_wready, bus.o_arready} !== (is_write ? 3'b110 : 3'b001)) begin
      failures++;
      $display("FAIL %s grant: got aw/w/ar ready=%b expected %b", name,
               {bus.o_awready, bus.o_wready, bus.o_arready}, (is_write ? 3'b110 : 3'b001));
    end
    @(negedge clk);
    bus.i_awvalid = 1'b0; bus.i_wvalid = 1'b0; bus.i_arvalid = 1'b0;
    #1;
    checks++;
    if ({bus.o_request, bus.o_direction} !== {1'b1, exp_q[0].dir}) begin
      failures++;
      $display("FAIL %s request: got req/dir=%b expected %b", name,
               {bus.o_request, bus.o_direction}, {1'b1, exp_q[0].dir});
    end
    checks++;
    if (bus.o_address !== exp_q[0].addr) begin
      failures++;
      $display("FAIL %s address: got %h expected %h", name, bus.o_address, exp_q[0].addr);
    end
    checks++;
    if (bus.o_write_data !== exp_q[0].wdata) begin
      failures++;
      $display("FAIL %s write_data: got %h expected %h", name, bus.o_write_data, exp_q[0].wdata);
    end
    checks++;
    if (bus.o_write_mask !== exp_q[0].mask) begin
      failures++;
      $display("FAIL %s write_mask: got %h expected %h", name, bus.o_write_mask, exp_q[0].mask);
    end
    bus.i_ready = 1'b1; bus.i_read_data = rd; bus.i_status = st;
    @(negedge clk);
    bus.i_ready = 1'b0; bus.i_read_data = '0; bus.i_status = '0;
    #1;
    got = exp_q.pop_front();
    resp_exp = got.dir ? {1'b1, 1'b0, got.resp, 2'b00, 32'h0}
                       : {1'b0, 1'b1, 2'b00, got.resp, got.rdata};
    checks++;
    if ({bus.o_bvalid, bus.o_rvalid, bus.o_bresp, bus.o_rresp, bus.o_rdata} !== resp_exp) begin
      failures++;
      $display("FAIL %s response: got bv/rv/bresp/rresp/rdata=%h expected %h", name,
               {bus.o_bvalid, bus.o_rvalid, bus.o_bresp, bus.o_rresp, bus.o_rdata}, resp_exp);
    end
    if (hold > 0) begin
      bus.i_awvalid = 1'b1; bus.i_wvalid = 1'b1; bus.i_arvalid = 1'b1;
    end
    for (int unsigned c = 0; c < hold; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus.o_awready, bus.o_wready, bus.o_arready, bus.o_request} !== 4'b0000) begin
        failures++;
        $display("FAIL %s hold_grant cycle %0d: got %b expected 0000", name, c,
                 {bus.o_awready, bus.o_wready, bus.o_arready, bus.o_request});
      end
      checks++;
      if ({bus.o_bvalid, bus.o_rvalid, bus.o_bresp, bus.o_rresp, bus.o_rdata} !== resp_exp) begin
        failures++;
        $display("FAIL %s hold_stable cycle %0d: got %h expected %h", name, c,
                 {bus.o_bvalid, bus.o_rvalid, bus.o_bresp, bus.o_rresp, bus.o_rdata}, resp_exp);
      end
    end
    if (is_write) bus.i_bready = 1'b1;
    else          bus.i_rready = 1'b1;
    #1;
    checks++;
    if ({bus.o_awready, bus.o_wready, bus.o_arready} !== 3'b000) begin
      failures++;
      $display("FAIL %s handshake_grant: got %b expected 000", name,
               {bus.o_awready, bus.o_wready, bus.o_arready});
    end
    @(negedge clk);
    bus.i_bready = 1'b0; bus.i_rready = 1'b0;
    bus.i_awvalid = 1'b0; bus.i_wvalid = 1'b0; bus.i_arvalid = 1'b0;
    #1;
    checks++;
    if ({bus.o_bvalid, bus.o_rvalid, bus.o_request} !== 3'b000) begin
      failures++;
      $display("FAIL %s release: got bv/rv/req=%b expected 000", name,
               {bus.o_bvalid, bus.o_rvalid, bus.o_request});
    end
  endtask

  task automatic test_single_write();
    single_access("single_write", 1'b1, 16'h0010, 32'hDEADBEEF, 4'b0101, 32'h00FF00FF,
                  32'hFFFFFFFF, RGGEN_OKAY, 0, 0);
  endtask

  task automatic test_single_read();
    single_access("single_read", 1'b0, 16'h0004, 32'h0, 4'b0000, 32'h0,
                  32'h12345678, RGGEN_SLAVE_ERROR, 0, 0);
  endtask

  task automatic test_aw_without_w();
    single_access("aw_without_w", 1'b1, 16'h0008, 32'h000000A5, 4'b0001, 32'h000000FF,
                  32'h0, RGGEN_EXOKAY, 10, 0);
  endtask

  task automatic test_backpressure();
    single_access("bp_write", 1'b1, 16'h000C, 32'hCAFEF00D, 4'b1100, 32'hFFFF0000,
                  32'h0, RGGEN_DECODE_ERROR, 0, 5);
    single_access("bp_read", 1'b0, 16'h0018, 32'h0, 4'b0000, 32'h0,
                  32'h87654321, RGGEN_OKAY, 0, 3);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_order = 4'b0101;
    int unsigned grants = 0;
    int unsigned resps  = 0;
    int unsigned cyc    = 0;
    exp_t e, got;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    bus.i_awvalid = 1'b1; bus.i_wvalid = 1'b1; bus.i_awaddr = 16'h0020;
    bus.i_wdata = 32'hA5A50001; bus.i_wstrb = 4'hF;
    bus.i_arvalid = 1'b1; bus.i_araddr = 16'h0024;
    bus.i_bready = 1'b1; bus.i_rready = 1'b1;
    bus.i_read_data = 32'h0BADF00D;
    while ((resps < 4) && (cyc < 60)) begin
      #1;
      if (bus.o_awready || bus.o_arready) begin
        checks++;
        if ((grants >= 4) || (bus.o_awready !== exp_order[grants[1:0]]) || (cyc != 3 * grants)) begin
          failures++;
          $display("FAIL b2b_grant #%0d: got write=%b at cycle %0d expected write=%b at cycle %0d",
                   grants, bus.o_awready, cyc, exp_order[grants[1:0]], 3 * grants);
        end
        e.dir   = bus.o_awready;
        e.addr  = bus.o_awready ? 16'h0020 : 16'h0024;
        e.wdata = bus.o_awready ? 32'hA5A50001 : 32'h0;
        e.mask  = bus.o_awready ? 32'hFFFFFFFF : 32'h0;
        e.rdata = bus.o_awready ? 32'h0 : 32'h0BADF00D;
        e.resp  = bus.o_awready ? RGGEN_EXOKAY : RGGEN_OKAY;
        exp_q.push_back(e);
        grants++;
      end
      if (bus.o_bvalid || bus.o_rvalid) begin
        got = (exp_q.size() > 0) ? exp_q.pop_front() : e;
        checks++;
        if ({bus.o_bvalid, (bus.o_bvalid ? bus.o_bresp : bus.o_rresp), bus.o_rdata} !==
            {got.dir, got.resp, got.rdata}) begin
          failures++;
          $display("FAIL b2b_resp #%0d: got bvalid/resp/rdata=%b/%b/%h expected %b/%b/%h", resps,
                   bus.o_bvalid, (bus.o_bvalid ? bus.o_bresp : bus.o_rresp), bus.o_rdata,
                   got.dir, got.resp, got.rdata);
        end
        resps++;
      end
      bus.i_ready  = bus.o_request;
      bus.i_status = (bus.o_direction == RGGEN_WRITE) ? RGGEN_EXOKAY : RGGEN_OKAY;
      @(negedge clk);
      if (grants >= 4) begin
        bus.i_awvalid = 1'b0; bus.i_wvalid = 1'b0; bus.i_arvalid = 1'b0;
      end
      cyc++;
    end
    bus.i_ready = 1'b0; bus.i_status = '0; bus.i_read_data = '0;
    bus.i_bready = 1'b0; bus.i_rready = 1'b0;
    bus.i_awvalid = 1'b0; bus.i_wvalid = 1'b0; bus.i_arvalid = 1'b0;
    checks++;
    if ((resps != 4) || (grants != 4)) begin
      failures++;
      $display("FAIL b2b_count: got grants=%0d resps=%0d expected 4/4", grants, resps);
    end
  endtask

  task automatic test_reset_in_access();
    exp_t e;
    e.dir = 1'b0; e.addr = 16'h0040; e.wdata = '0; e.mask = '0; e.rdata = '0; e.resp = '0;
    exp_q.push_back(e);
    @(negedge clk);
    bus.i_arvalid = 1'b1; bus.i_araddr = 16'h0040;
    @(negedge clk);
    bus.i_arvalid = 1'b0;
    #1;
    checks++;
    if ({bus.o_request, bus.o_address} !== {1'b1, exp_q[0].addr}) begin
      failures++;
      $display("FAIL rst_access_pre: got req/addr=%b/%h expected 1/%h",
               bus.o_request, bus.o_address, exp_q[0].addr);
    end
    #2;
    rst = 1'b1;
    #1;
    void'(exp_q.pop_front());
    checks++;
    if ({bus.o_request, bus.o_bvalid, bus.o_rvalid, bus.o_address, bus.o_direction} !== '0) begin
      failures++;
      $display("FAIL rst_access_async: got req/bv/rv=%b addr=%h expected all 0",
               {bus.o_request, bus.o_bvalid, bus.o_rvalid}, bus.o_address);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.o_request, bus.o_rvalid} !== 2'b00) begin
      failures++;
      $display("FAIL rst_access_after: got req/rv=%b expected 00", {bus.o_request, bus.o_rvalid});
    end
  endtask

`ifdef RGGEN_HOST_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    int unsigned req_cycles = 0;
    int unsigned cyc = 0;
    @(negedge clk);
    bus.i_arvalid = 1'b1; bus.i_araddr = 16'h0030; bus.i_read_data = 32'hFFFFFFFF;
    @(negedge clk);
    bus.i_arvalid = 1'b0;
    #1;
    while ((bus.o_request === 1'b1) && (cyc < 50)) begin
      req_cycles++;
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (req_cycles != 4) begin
      failures++;
      $display("FAIL timeout_req_cycles: got %0d expected 4", req_cycles);
    end
    checks++;
    if ({bus.o_rvalid, bus.o_rresp, bus.o_rdata} !== {1'b1, 2'b10, 32'h0}) begin
      failures++;
      $display("FAIL timeout_resp: got rvalid/rresp/rdata=%b/%b/%h expected 1/10/00000000",
               bus.o_rvalid, bus.o_rresp, bus.o_rdata);
    end
    bus.i_rready = 1'b1;
    @(negedge clk);
    bus.i_rready = 1'b0;
    @(negedge clk);
    bus.i_arvalid = 1'b1; bus.i_araddr = 16'h0034;
    @(negedge clk);
    bus.i_arvalid = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_ready = 1'b1; bus.i_status = RGGEN_OKAY; bus.i_read_data = 32'h600DCAFE;
    #1;
    checks++;
    if (bus.o_request !== 1'b1) begin
      failures++;
      $display("FAIL timeout_edge_req: got %b expected 1", bus.o_request);
    end
    @(negedge clk);
    bus.i_ready = 1'b0; bus.i_read_data = '0;
    #1;
    checks++;
    if ({bus.o_rvalid, bus.o_rresp, bus.o_rdata} !== {1'b1, 2'b00, 32'h600DCAFE}) begin
      failures++;
      $display("FAIL timeout_edge_resp: got rvalid/rresp/rdata=%b/%b/%h expected 1/00/600dcafe",
               bus.o_rvalid, bus.o_rresp, bus.o_rdata);
    end
    bus.i_rready = 1'b1;
    @(negedge clk);
    bus.i_rready = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    int unsigned req_cycles = 0;
    @(negedge clk);
    bus.i_arvalid = 1'b1; bus.i_araddr = 16'h0030;
    @(negedge clk);
    bus.i_arvalid = 1'b0;
    for (int unsigned c = 0; c < 20; c++) begin
      #1;
      if (bus.o_request === 1'b1) req_cycles++;
      @(negedge clk);
    end
    checks++;
    if ((req_cycles != 20) || (bus.o_rvalid !== 1'b0)) begin
      failures++;
      $display("FAIL no_timeout_wait: got request cycles=%0d rvalid=%b expected 20/0",
               req_cycles, bus.o_rvalid);
    end
    bus.i_ready = 1'b1; bus.i_status = RGGEN_OKAY; bus.i_read_data = 32'h00C0FFEE;
    @(negedge clk);
    bus.i_ready = 1'b0; bus.i_read_data = '0;
    #1;
    checks++;
    if ({bus.o_rvalid, bus.o_rresp, bus.o_rdata} !== {1'b1, 2'b00, 32'h00C0FFEE}) begin
      failures++;
      $display("FAIL no_timeout_resp: got rvalid/rresp/rdata=%b/%b/%h expected 1/00/00c0ffee",
               bus.o_rvalid, bus.o_rresp, bus.o_rdata);
    end
    bus.i_rready = 1'b1;
    @(negedge clk);
    bus.i_rready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_single_write();
    test_single_read();
    test_aw_without_w();
    test_backpressure();
    test_reset_in_access();
`ifdef RGGEN_HOST_ACCESS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rggen_host_adapter_axi4lite.md
Name: rggen_host_adapter_axi4lite

Overview:
- AXI4-Lite slave front end that converts host transactions into single register-bus accesses (request/direction/address/write data/write mask out; ready/read data/status back).
- Sits directly upstream of the per-register address-decode stage: its register-bus outputs fan out to every register, and the muxed ready/read data/status come back.
- One outstanding access at a time; read/write contention resolved round-robin.

Parameters:
- ADDRESS_WIDTH, 16, byte address width on AXI and the register bus.
- DATA_WIDTH, 32, bus data width; legal values are 32 and 64.
- TIMEOUT_CYCLES, 256, request cycles before forced error; used only with the optional feature; must be ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_awvalid / o_awready  in/out  1  write address handshake
- i_awaddr  in  ADDRESS_WIDTH  write address
- i_wvalid / o_wready  in/out  1  write data handshake
- i_wdata  in  DATA_WIDTH  write data
- i_wstrb  in  DATA_WIDTH/8  byte strobes
- o_bvalid / i_bready  out/in  1  write response handshake
- o_bresp  out  2  write response
- i_arvalid / o_arready  in/out  1  read address handshake
- i_araddr  in  ADDRESS_WIDTH  read address
- o_rvalid / i_rready  out/in  1  read response handshake
- o_rdata  out  DATA_WIDTH  read data
- o_rresp  out  2  read response
- o_request  out  1  register access request
- o_direction  out  1  rggen_direction (RGGEN_READ/RGGEN_WRITE)
- o_address  out  ADDRESS_WIDTH  access address
- o_write_data / o_write_mask  out  DATA_WIDTH  write data and bit mask
- i_ready  in  1  access complete
- i_read_data  in  DATA_WIDTH  read data
- i_status  in  2  rggen_status

Behaviour:
- Clock and reset: single clk; rst is asynchronous and active-high. Reset clears every register and returns the FSM to IDLE. After reset all outputs are 0 and the round-robin pointer is last_grant=READ, so write wins the first tie.
- IDLE:
  - A write is pending when i_awvalid && i_wvalid; AW alone or W alone is never accepted. A read is pending when i_arvalid.
  - Grant is combinational. o_awready=o_wready=grant_write and o_arready=grant_read, asserted for exactly this one cycle.
  - On a tie, grant the opposite of last_grant.
  - On grant: capture address and direction. For a write, capture wdata and mask[8i+7:8i]={8{wstrb[i]}}; for a read, write_data and write_mask are 0. Update last_grant and go to ACCESS.
- ACCESS:
  - o_request=1; o_direction, o_address, o_write_data and o_write_mask are held stable.
  - On i_ready: capture i_read_data (reads only, else 0) and i_status, then go to RESPONSE.
- RESPONSE:
  - Write: o_bvalid=1 and o_bresp=captured status.
  - Read: o_rvalid=1, o_rresp=captured status, o_rdata=captured data.
  - Outputs hold until i_bready/i_rready; on handshake return to IDLE. No new grant is possible in that same cycle.
- Latency: grant at cycle N, o_request at N+1; with i_ready at N+1, valid response at N+2. Minimum turnaround is 3 cycles per access.
- Status pass-through: the 2-bit rggen_status value maps directly to AXI resp.
- Reset mid-operation: request and valid outputs drop immediately; the captured transaction is discarded.

Optional Feature:
- Macro: RGGEN_HOST_ACCESS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without i_ready.
  - When the counter reaches TIMEOUT_CYCLES-1 without i_ready, drop o_request next cycle and enter RESPONSE with resp=RGGEN_SLAVE_ERROR and rdata=0.
  - i_ready on the expiry cycle wins: normal response.
- Undefined: no counter; ACCESS waits indefinitely for i_ready.

Decomposition:
- Shared package rggen_rtl_pkg:
  - typedef enum rggen_direction {RGGEN_READ=0, RGGEN_WRITE=1}
  - typedef enum logic[1:0] rggen_status {RGGEN_OKAY=0, RGGEN_EXOKAY=1, RGGEN_SLAVE_ERROR=2, RGGEN_DECODE_ERROR=3}
- FSM state enum is local to the module.
- One sub-module: rggen_host_access_timer (counter plus expiry flag), instantiated only under the macro.

Test Plan:
- Single write: addr 0x0010, wdata 0xDEADBEEF, wstrb 4'b0101 -> o_write_mask 0x00FF00FF; i_ready 1 cycle later -> bvalid 2 cycles after grant, bresp 0.
- Single read: araddr 0x0004, i_read_data 0x12345678, i_status SLAVE_ERROR -> rdata 0x12345678, rresp 2'b10.
- Simultaneous AW+W+AR for 4 back-to-back transactions -> grants alternate W,R,W,R; first grant is the write after reset.
- AW without W for 10 cycles -> awready stays 0 and no o_request; W arrives -> both readies rise in the same cycle.
- Backpressure: hold i_bready=0 for 5 cycles -> bvalid and bresp stable and no new grant; rst pulsed in ACCESS -> all outputs 0 asynchronously.
- With macro and TIMEOUT_CYCLES=4, i_ready never asserted -> o_request high for exactly 4 cycles, then rresp 2'b10, rdata 0; i_ready on cycle 4 -> normal OKAY response.
